// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the UART receiver, the receive FIFO and its consumer.
// The FIFO takes the slave side; the receiver/consumer (or a bench) takes the master side.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    logic [7:0]             rx_data;
    logic                   rx_done;
    logic [7:0]             rd_data;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic                   overrun;
    logic                   clr_overrun;
    logic                   rx_timeout;

    modport master (
        output rx_data, rx_done, rd_ready, clr_overrun,
        input  rd_data, rd_valid, count, full, empty, overrun, rx_timeout
    );

    modport slave (
        input  rx_data, rx_done, rd_ready, clr_overrun,
        output rd_data, rd_valid, count, full, empty, overrun, rx_timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: show-ahead valid/ready read port,
// sticky overrun flag and a character-timeout flag for lazily draining consumers.
module uart_rx_fifo #(
    parameter int clk_hz        = 50_000_000,
    parameter int baud_rate     = 9600,
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_CHARS = 4
) (
    input logic            clk,
    input logic            rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int CPB     = clk_hz / baud_rate;
    localparam int TO_CLKS = TIMEOUT_CHARS * 10 * CPB;
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int TW      = $clog2(TO_CLKS + 1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    logic [TW-1:0] r_toCnt;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_overrunEvt;
    logic w_toHit;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign w_push       = bus.rx_done && (!w_full || w_pop);
    assign w_overrunEvt = bus.rx_done && w_full && !w_pop;
    assign w_toHit      = (r_toCnt == TW'(TO_CLKS));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority so an overrun coinciding with a clear is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (w_overrunEvt) begin
            r_overrun <= 1'b1;
        end else if (bus.clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toCnt <= '0;
        end else if (w_push || w_pop || w_empty) begin
            r_toCnt <= '0;
        end else if (!w_toHit) begin
            r_toCnt <= r_toCnt + TW'(1);
        end
    end

    assign bus.rd_data    = w_empty ? 8'h00 : r_mem[r_rdPtr];
    assign bus.rd_valid   = !w_empty;
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overrun    = r_overrun;
    assign bus.rx_timeout = w_toHit && !w_empty;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD    = 1_000_000;
    localparam int DEPTH   = 16;
    localparam int TO_CLKS = 4 * 10 * (CLK_HZ / BAUD);

    logic clk;
    logic rst;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .clk_hz       (CLK_HZ),
        .baud_rate    (BAUD),
        .DEPTH        (DEPTH),
        .TIMEOUT_CHARS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: contents as a queue, activity as a timestamp of edges.
    logic [7:0] modelQ[$];
    logic       modelOverrun;
    int         cycleNo;
    int         lastActivity;

    typedef struct {
        logic       rxDone;
        logic [7:0] rxData;
        logic       rdReady;
        int         expCount;
        logic [7:0] expData;
        logic       expValid;
    } vecT;

    vecT vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelOverrun = 1'b0;
        lastActivity = cycleNo;
    endtask

    task automatic checkAgainstModel();
        int  sz;
        logic expTimeout;
        sz = modelQ.size();
        expTimeout = (sz != 0) && ((cycleNo - lastActivity) >= TO_CLKS);
        checkOutput("count", 32'(bus.count), 32'(sz));
        checkOutput("rd_valid", 32'(bus.rd_valid), 32'(sz != 0));
        checkOutput("rd_data", 32'(bus.rd_data), (sz != 0) ? 32'(modelQ[0]) : 32'h0);
        checkOutput("full", 32'(bus.full), 32'(sz == DEPTH));
        checkOutput("empty", 32'(bus.empty), 32'(sz == 0));
        checkOutput("overrun", 32'(bus.overrun), 32'(modelOverrun));
        checkOutput("rx_timeout", 32'(bus.rx_timeout), 32'(expTimeout));
    endtask

    task automatic modelEdge(input logic d, input logic [7:0] data, input logic rdy, input logic clr);
        logic wasEmpty;
        logic pop;
        logic pushed;
        logic lost;
        wasEmpty = (modelQ.size() == 0);
        pop      = !wasEmpty && rdy;
        pushed   = d && ((modelQ.size() < DEPTH) || pop);
        lost     = d && !pushed;
        if (pop) void'(modelQ.pop_front());
        if (pushed) modelQ.push_back(data);
        if (lost) modelOverrun = 1'b1;
        else if (clr) modelOverrun = 1'b0;
        cycleNo++;
        if (pushed || pop || wasEmpty) lastActivity = cycleNo;
    endtask

    // One clock: check current outputs, drive inputs, clock, advance the model.
    task automatic applyStimulus(input logic d, input logic [7:0] data, input logic rdy, input logic clr);
        checkAgainstModel();
        bus.rx_done     = d;
        bus.rx_data     = data;
        bus.rd_ready    = rdy;
        bus.clr_overrun = clr;
        @(posedge clk);
        modelEdge(d, data, rdy, clr);
        #1;
        bus.rx_done     = 1'b0;
        bus.rd_ready    = 1'b0;
        bus.clr_overrun = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1, 8'hA5, 1'b1};
        vecs[1] = '{1'b1, 8'h3C, 1'b0, 2, 8'hA5, 1'b1};
        vecs[2] = '{1'b1, 8'hFF, 1'b0, 3, 8'hA5, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 2, 8'h3C, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1, 8'hFF, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 8'h11, 1'b1, 1, 8'h11, 1'b1};
        vecs[7] = '{1'b1, 8'h22, 1'b1, 1, 8'h22, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 0, 8'h00, 1'b0};

        cycleNo         = 0;
        rst             = 1'b1;
        bus.rx_done     = 1'b0;
        bus.rx_data     = 8'h00;
        bus.rd_ready    = 1'b0;
        bus.clr_overrun = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();

        $display("[TB] reset and idle");
        repeat (100) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].rxDone, vecs[i].rxData, vecs[i].rdReady, 1'b0);
            checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d_data", i), 32'(bus.rd_data), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vecs[i].expValid));
        end

        $display("[TB] fill, overrun, drain, clear");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("fill_full", 32'(bus.full), 32'h1);
        checkOutput("fill_overrun", 32'(bus.overrun), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("drain%0d", i), 32'(bus.rd_data), 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drain_empty", 32'(bus.empty), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clr_overrun", 32'(bus.overrun), 32'h0);

        $display("[TB] push and pop while full");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
        checkOutput("pp_count", 32'(bus.count), 32'(DEPTH));
        checkOutput("pp_overrun", 32'(bus.overrun), 32'h0);
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pp_last_byte", 32'(bus.rd_data), 32'h77);
        checkOutput("pp_last_count", 32'(bus.count), 32'h1);
        applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
        checkOutput("pp_not_lost", 32'(bus.count), 32'h2);

        $display("[TB] overrun and clear in the same cycle");
        for (int i = 0; i < DEPTH - 2; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1);
        checkOutput("set_wins", 32'(bus.overrun), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] character timeout");
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        for (int i = 1; i < TO_CLKS; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("to_before", 32'(bus.rx_timeout), 32'h0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("to_exact", 32'(bus.rx_timeout), 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("to_pop_clear", 32'(bus.rx_timeout), 32'h0);
        repeat (TO_CLKS + 50) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("to_empty_low", 32'(bus.rx_timeout), 32'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] overruns do not restart the timeout");
        for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < TO_CLKS + 20; i++) applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'b0);
        checkOutput("ovr_to_timeout", 32'(bus.rx_timeout), 32'h1);
        checkOutput("ovr_to_overrun", 32'(bus.overrun), 32'h1);

        $display("[TB] asynchronous reset mid-stream");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        checkAgainstModel();
        checkOutput("pre_rst_count", 32'(bus.count), 32'h5);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_count", 32'(bus.count), 32'h0);
        checkOutput("rst_valid", 32'(bus.rd_valid), 32'h0);
        checkOutput("rst_data", 32'(bus.rd_data), 32'h0);
        checkOutput("rst_empty", 32'(bus.empty), 32'h1);
        checkOutput("rst_full", 32'(bus.full), 32'h0);
        checkOutput("rst_overrun", 32'(bus.overrun), 32'h0);
        checkOutput("rst_timeout", 32'(bus.rx_timeout), 32'h0);
        @(posedge clk);
        cycleNo++;
        #1;
        rst = 1'b0;
        modelReset();
        applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
        checkOutput("post_rst_data", 32'(bus.rd_data), 32'h12);
        checkOutput("post_rst_count", 32'(bus.count), 32'h1);
        checkAgainstModel();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
